processing_element_v2: RTL and testbench

Parametrised second-generation systolic-array processing element. It generalises data and accumulator widths and supports two runtime modes: weight-stationary (WS) and output-stationary (OS). It adds per-lane valid flags, double-buffered weights with an explicit swap, a sticky saturation flag, and an OS drain state machine. The drain shifts each PE's accumulator down its column as a last-tagged stream. One instance sits at each grid point of the array, and the array controller drives the shared control inputs.

---
 rtl/systolic_pkg.sv | 34 +++
 rtl/pe_sat_mac.sv | 38 +++
 rtl/processing_element_v2.sv | 160 ++++++++++++++++
 tb/tb_processing_element_v2.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic processing elements.
// Saturation helper works on a wide signed value and a runtime width.
package systolic_pkg;

  typedef enum logic {
    PE_WS = 1'b0,
    PE_OS = 1'b1
  } pe_mode_e;

  typedef enum logic {
    PE_RUN       = 1'b0,
    PE_DRAIN_FWD = 1'b1
  } pe_state_e;

  localparam int unsigned SAT_MAXW = 64;

  // Clamp a sign-extended value into the signed range of w bits.
  function automatic logic signed [SAT_MAXW-1:0] sat_s(
    input logic signed [SAT_MAXW-1:0] v,
    input int unsigned                w
  );
    logic signed [SAT_MAXW-1:0] hi;
    logic signed [SAT_MAXW-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)
      sat_s = hi;
    else if (v < lo)
      sat_s = lo;
    else
      sat_s = v;
  endfunction

endpackage

// File: rtl/pe_sat_mac.sv
// Combinational multiply-add with saturation.
// Used for both the WS partial sum and the OS accumulator.
module pe_sat_mac
  import systolic_pkg::*;
#(
  parameter int IN_WIDTH  = 8,
  parameter int ACC_WIDTH = 24
) (
  input  logic signed [IN_WIDTH-1:0]  i_a,
  input  logic signed [IN_WIDTH-1:0]  i_b,
  input  logic                        i_use_prod,
  input  logic signed [ACC_WIDTH-1:0] i_addend,
  output logic signed [ACC_WIDTH-1:0] o_sum,
  output logic                        o_sat
);

  localparam int PW = 2 * IN_WIDTH;
  localparam int SW = ACC_WIDTH + 1;

  logic signed [PW-1:0]       w_raw;
  logic signed [PW-1:0]       w_prod;
  logic        [SW-1:0]       w_wide;
  logic signed [SAT_MAXW-1:0] w_ext;
  logic signed [SAT_MAXW-1:0] w_clamp;

  assign w_raw  = i_a * i_b;
  assign w_prod = i_use_prod ? w_raw : '0;

  // One guard bit is enough: both operands fit in ACC_WIDTH.
  assign w_wide = {i_addend[ACC_WIDTH-1], i_addend}
                + {{(SW-PW){w_prod[PW-1]}}, w_prod};

  assign w_ext   = {{(SAT_MAXW-SW){w_wide[SW-1]}}, w_wide};
  assign w_clamp = sat_s(w_ext, ACC_WIDTH);
  assign o_sum   = w_clamp[ACC_WIDTH-1:0];
  assign o_sat   = (w_clamp != w_ext);

endmodule

// File: rtl/processing_element_v2.sv
// Systolic PE with WS/OS modes, double-buffered weight,
// sticky saturation flag and OS column drain.
module processing_element_v2
  import systolic_pkg::*;
#(
  parameter int IN_WIDTH  = 8,
  parameter int ACC_WIDTH = 24
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 mode_i,
  input  logic [IN_WIDTH-1:0]  west_i,
  input  logic                 west_valid_i,
  output logic [IN_WIDTH-1:0]  east_o,
  output logic                 east_valid_o,
  input  logic [ACC_WIDTH-1:0] north_i,
  input  logic                 north_valid_i,
  input  logic                 north_last_i,
  output logic [ACC_WIDTH-1:0] south_o,
  output logic                 south_valid_o,
  output logic                 south_last_o,
  input  logic                 wload_i,
  input  logic                 wswap_i,
  input  logic                 acc_clr_i,
  input  logic                 drain_i,
  input  logic                 top_row_i,
  output logic                 busy_o,
  output logic                 sat_o
);

  logic [IN_WIDTH-1:0]         r_east;
  logic                        r_east_v;
  logic [ACC_WIDTH-1:0]        r_south;
  logic                        r_south_v;
  logic                        r_south_last;
  pe_state_e                   r_state;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [IN_WIDTH-1:0]  r_act_w;
  logic signed [IN_WIDTH-1:0]  r_shd_w;
  logic                        r_sat;

  logic                        w_os;
  logic                        w_fwd;
  logic                        w_ws_run;
  logic                        w_os_run;
  logic                        w_both;
  logic signed [IN_WIDTH-1:0]  w_b;
  logic                        w_use;
  logic signed [ACC_WIDTH-1:0] w_add;
  logic signed [ACC_WIDTH-1:0] w_sum;
  logic                        w_sat;

  assign w_os     = (pe_mode_e'(mode_i) == PE_OS);
  assign w_fwd    = (r_state == PE_DRAIN_FWD);
  assign w_ws_run = !w_fwd && !w_os;
  assign w_os_run = !w_fwd && w_os;
  assign w_both   = west_valid_i && north_valid_i;

  // WS: psum + x*w_active. OS: acc + x*north operand.
  assign w_b   = w_os ? north_i[IN_WIDTH-1:0] : r_act_w;
  assign w_use = w_os ? w_both : 1'b1;
  assign w_add = w_os ? r_acc
               : (north_valid_i ? north_i : '0);

  pe_sat_mac #(
    .IN_WIDTH  (IN_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .i_a        (west_i),
    .i_b        (w_b),
    .i_use_prod (w_use),
    .i_addend   (w_add),
    .o_sum      (w_sum),
    .o_sat      (w_sat)
  );

  // Lanes, weights, accumulator and drain FSM.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_east       <= '0;
      r_east_v     <= 1'b0;
      r_south      <= '0;
      r_south_v    <= 1'b0;
      r_south_last <= 1'b0;
      r_state      <= PE_RUN;
      r_acc        <= '0;
      r_act_w      <= '0;
      r_shd_w      <= '0;
      r_sat        <= 1'b0;
    end else begin
      r_east   <= west_i;
      r_east_v <= west_valid_i;
      unique case (1'b1)
        w_fwd: begin
          r_south      <= north_i;
          r_south_v    <= north_valid_i;
          r_south_last <= north_last_i;
          if (north_valid_i && north_last_i)
            r_state <= PE_RUN;
        end
        w_ws_run: begin
          if (wswap_i)
            r_act_w <= r_shd_w;
          if (wload_i) begin
            if (north_valid_i)
              r_shd_w <= north_i[IN_WIDTH-1:0];
            r_south      <= north_i;
            r_south_v    <= north_valid_i;
            r_south_last <= north_last_i;
          end else begin
            r_south_v    <= west_valid_i;
            r_south_last <= 1'b0;
            if (west_valid_i)
              r_south <= w_sum;
          end
          if (acc_clr_i)
            r_sat <= 1'b0;
          else if (!wload_i && west_valid_i && w_sat)
            r_sat <= 1'b1;
        end
        w_os_run: begin
          if (drain_i) begin
            r_south      <= w_sum;
            r_south_v    <= 1'b1;
            r_south_last <= top_row_i;
            r_acc        <= '0;
            if (!top_row_i)
              r_state <= PE_DRAIN_FWD;
            if (acc_clr_i)
              r_sat <= 1'b0;
            else if (w_sat)
              r_sat <= 1'b1;
          end else begin
            r_south      <= north_i;
            r_south_v    <= north_valid_i;
            r_south_last <= north_last_i;
            if (acc_clr_i) begin
              r_acc <= '0;
              r_sat <= 1'b0;
            end else if (w_both) begin
              r_acc <= w_sum;
              if (w_sat)
                r_sat <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign east_o        = r_east;
  assign east_valid_o  = r_east_v;
  assign south_o       = r_south;
  assign south_valid_o = r_south_v;
  assign south_last_o  = r_south_last;
  assign busy_o        = w_fwd;
  assign sat_o         = r_sat;

endmodule

// File: tb/tb_processing_element_v2.sv
// Bench: a 3-row column of PEs, random and directed traffic,
// bottom-of-column scoreboard against a behavioural model.
module tb_processing_element_v2;

  localparam int IW = 8;
  localparam int AW = 16;
  localparam int R  = 3;
  localparam longint MAXV = (64'sd1 <<< (AW - 1)) - 64'sd1;
  localparam longint MINV = -MAXV - 64'sd1;

  typedef struct {
    longint d;
    bit     l;
  } exp_t;

  logic clk = 1'b0;
  logic rst, mode, wload, wswap, acc_clr, drain;
  logic [IW-1:0] west [R];
  logic          wv   [R];
  logic [IW-1:0] east [R];
  logic          ev   [R];
  logic [AW-1:0] tb_n;
  logic          tb_nv, tb_nl;
  logic [AW-1:0] nin_d [R];
  logic          nin_v [R];
  logic          nin_l [R];
  logic [AW-1:0] sd [R];
  logic          sv [R];
  logic          sl [R];
  logic          busy [R];
  logic          sat  [R];

  int checks = 0;
  int failures = 0;

  exp_t   exp_q[$];
  longint act [R];
  longint shd [R];
  longint acc [R];
  bit     msat [R];

  logic [AW-1:0] vp  [16];
  bit            vpv [16];
  logic [IW-1:0] vx  [16][R];

  always #5 clk = ~clk;

  for (genvar r = 0; r < R; r++) begin : g_col
    if (r == 0) begin : g_top
      assign nin_d[r] = tb_n;
      assign nin_v[r] = tb_nv;
      assign nin_l[r] = tb_nl;
    end else begin : g_mid
      assign nin_d[r] = sd[r-1];
      assign nin_v[r] = sv[r-1];
      assign nin_l[r] = sl[r-1];
    end
    processing_element_v2 #(
      .IN_WIDTH  (IW),
      .ACC_WIDTH (AW)
    ) u_pe (
      .clk_i         (clk),
      .rst_i         (rst),
      .mode_i        (mode),
      .west_i        (west[r]),
      .west_valid_i  (wv[r]),
      .east_o        (east[r]),
      .east_valid_o  (ev[r]),
      .north_i       (nin_d[r]),
      .north_valid_i (nin_v[r]),
      .north_last_i  (nin_l[r]),
      .south_o       (sd[r]),
      .south_valid_o (sv[r]),
      .south_last_o  (sl[r]),
      .wload_i       (wload),
      .wswap_i       (wswap),
      .acc_clr_i     (acc_clr),
      .drain_i       (drain),
      .top_row_i     (r == 0),
      .busy_o        (busy[r]),
      .sat_o         (sat[r])
    );
  end

  function automatic longint sxa(input logic [AW-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint sxi(input logic [IW-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint clampv(input longint v, output bit c);
    c = 1'b0;
    if (v > MAXV) begin
      c = 1'b1;
      return MAXV;
    end
    if (v < MINV) begin
      c = 1'b1;
      return MINV;
    end
    return v;
  endfunction

  task automatic chk(input string nm, input longint got, input longint expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, expv, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    wload   = 1'b0;
    wswap   = 1'b0;
    acc_clr = 1'b0;
    drain   = 1'b0;
    tb_n    = AW'($urandom);
    tb_nv   = 1'b0;
    tb_nl   = 1'b0;
    for (int r = 0; r < R; r++) begin
      west[r] = IW'($urandom);
      wv[r]   = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    drive_idle();
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic model_reset();
    for (int r = 0; r < R; r++) begin
      act[r] = 0; shd[r] = 0; acc[r] = 0; msat[r] = 0;
    end
  endtask

  task automatic check_zero();
    for (int r = 0; r < R; r++) begin
      chk("rst_south", sxa(sd[r]), 0);
      chk("rst_south_valid", sv[r], 0);
      chk("rst_south_last", sl[r], 0);
      chk("rst_east", sxi(east[r]), 0);
      chk("rst_east_valid", ev[r], 0);
      chk("rst_busy", busy[r], 0);
      chk("rst_sat", sat[r], 0);
    end
  endtask

  task automatic check_sat();
    for (int r = 0; r < R; r++) chk("sat_flag", sat[r], msat[r]);
  endtask

  task automatic check_busy(input bit b0, input bit b1, input bit b2);
    chk("busy_r0", busy[0], b0);
    chk("busy_r1", busy[1], b1);
    chk("busy_r2", busy[2], b2);
  endtask

  // Weights enter at the top as a stream w2,w1,w0 and shift down.
  task automatic ws_load(input longint w0, input longint w1,
                         input longint w2, input bit swap_last);
    logic [AW-1:0] s [3];
    longint wl [3];
    wl = '{w0, w1, w2};
    for (int i = 0; i < 3; i++) begin
      s[i] = AW'($urandom);
      s[i][IW-1:0] = IW'(wl[2-i]);
    end
    exp_q.push_back('{sxa(s[0]), 1'b0});
    if (swap_last) begin
      for (int r = 0; r < 2; r++) act[r] = sxi(s[1-r][IW-1:0]);
      act[2] = shd[2];
    end
    for (int r = 0; r < R; r++) shd[r] = sxi(s[2-r][IW-1:0]);
    for (int i = 0; i < 3; i++) begin
      drive_idle();
      tb_n  = s[i];
      tb_nv = 1'b1;
      wload = 1'b1;
      wswap = swap_last && (i == 2);
      tick();
    end
    idle(2);
  endtask

  task automatic ws_swap();
    drive_idle();
    wswap = 1'b1;
    for (int r = 0; r < R; r++) act[r] = shd[r];
    tick();
    idle(1);
  endtask

  task automatic rand_vecs(input int n);
    logic [11:0] t12;
    for (int k = 0; k < n; k++) begin
      t12 = 12'($urandom);
      vp[k] = $urandom_range(0, 1) ? AW'($urandom)
                                   : {{(AW-12){t12[11]}}, t12};
      vpv[k] = ($urandom_range(0, 3) != 0);
      for (int r = 0; r < R; r++) vx[k][r] = IW'($urandom);
    end
  endtask

  // Skewed WS vectors: row r sees vector k at cycle k+r.
  task automatic ws_run(input int n, input bit noise);
    longint s;
    bit c;
    for (int k = 0; k < n; k++) begin
      s = vpv[k] ? sxa(vp[k]) : 0;
      for (int r = 0; r < R; r++) begin
        s = clampv(s + sxi(vx[k][r]) * act[r], c);
        if (c) msat[r] = 1'b1;
      end
      exp_q.push_back('{s, 1'b0});
    end
    for (int cy = 0; cy < n + R - 1; cy++) begin
      drive_idle();
      for (int r = 0; r < R; r++) begin
        if (cy - r >= 0 && cy - r < n) begin
          west[r] = vx[cy-r][r];
          wv[r]   = 1'b1;
        end
      end
      if (cy < n) begin
        tb_n  = vp[cy];
        tb_nv = vpv[cy];
      end
      drain = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    idle(4);
  endtask

  // OS operands stream down; row r multiplies word k at cycle k+r.
  task automatic os_stream(input int n, input bit noise,
                           input bit directed);
    logic [AW-1:0] b [16];
    logic [IW-1:0] a [16][R];
    bit av [16][R];
    bit c;
    for (int k = 0; k < n; k++) begin
      b[k] = AW'($urandom);
      for (int r = 0; r < R; r++) begin
        a[k][r]  = IW'($urandom);
        av[k][r] = ($urandom_range(0, 3) != 0);
      end
    end
    if (directed) begin
      b[0] = AW'(5);
      b[1] = AW'(4);
      a[0] = '{IW'(-1), IW'(1), IW'(2)};
      a[1] = '{IW'(3), IW'(1), IW'(-3)};
      for (int k = 0; k < 2; k++)
        for (int r = 0; r < R; r++) av[k][r] = 1'b1;
    end
    for (int k = 0; k < n; k++) begin
      for (int r = 0; r < R; r++) begin
        if (av[k][r]) begin
          acc[r] = clampv(acc[r] + sxi(a[k][r]) * sxi(b[k][IW-1:0]), c);
          if (c) msat[r] = 1'b1;
        end
      end
      exp_q.push_back('{sxa(b[k]), 1'b0});
    end
    for (int cy = 0; cy < n + R - 1; cy++) begin
      drive_idle();
      for (int r = 0; r < R; r++) begin
        if (cy - r >= 0 && cy - r < n) begin
          west[r] = a[cy-r][r];
          wv[r]   = av[cy-r][r];
        end
      end
      if (cy < n) begin
        tb_n  = b[cy];
        tb_nv = 1'b1;
      end
      if (noise) begin
        wload = 1'($urandom_range(0, 1));
        wswap = 1'($urandom_range(0, 1));
      end
      tick();
    end
    idle(4);
  endtask

  task automatic os_drain(input bit with_prod, input bit with_clr);
    logic [AW-1:0] b;
    logic [IW-1:0] a;
    longint e0;
    bit c;
    b  = AW'($urandom);
    a  = IW'($urandom);
    e0 = acc[0];
    if (with_prod) begin
      e0 = clampv(acc[0] + sxi(a) * sxi(b[IW-1:0]), c);
      if (c) msat[0] = 1'b1;
    end
    exp_q.push_back('{acc[2], 1'b0});
    exp_q.push_back('{acc[1], 1'b0});
    exp_q.push_back('{e0, 1'b1});
    for (int r = 0; r < R; r++) begin
      acc[r] = 0;
      if (with_clr) msat[r] = 1'b0;
    end
    drive_idle();
    drain   = 1'b1;
    acc_clr = with_clr;
    west[0] = a;
    wv[0]   = with_prod;
    tb_n    = b;
    tb_nv   = with_prod;
    tick();
    drive_idle();
    check_busy(1'b0, 1'b1, 1'b1);
    tick();
    check_busy(1'b0, 1'b0, 1'b1);
    tick();
    check_busy(1'b0, 1'b0, 1'b0);
    idle(3);
  endtask

  // Bottom-of-column scoreboard plus east-lane check.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    for (int r = 0; r < R; r++) begin
      chk("east_data", sxi(east[r]), rst ? 0 : sxi(west[r]));
      chk("east_valid", ev[r], rst ? 0 : wv[r]);
    end
    if (sv[R-1]) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word got=%0d exp=none t=%0t",
                 sxa(sd[R-1]), $time);
      end else begin
        e = exp_q.pop_front();
        chk("south_data", sxa(sd[R-1]), e.d);
        chk("south_last", sl[R-1], e.l);
      end
    end
  end

  initial begin
    rst  = 1'b1;
    mode = 1'b0;
    drive_idle();
    model_reset();
    tick();
    tick();
    check_zero();
    rst = 1'b0;
    idle(2);

    ws_load($urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 255), 1'b0);
    ws_swap();

    ws_load(3, 1, 2, 1'b0);
    ws_swap();
    vp[0] = AW'(100); vpv[0] = 1'b1;
    vx[0] = '{IW'(-4), IW'(0), IW'(0)};
    ws_run(1, 1'b0);

    rand_vecs(12);
    ws_run(12, 1'b1);
    check_sat();
    check_busy(1'b0, 1'b0, 1'b0);

    ws_load(127, 127, 127, 1'b0);
    ws_swap();
    vp[0] = AW'(32760); vpv[0] = 1'b1;
    vx[0] = '{IW'(127), IW'(0), IW'(0)};
    ws_run(1, 1'b0);
    check_sat();
    drive_idle();
    acc_clr = 1'b1;
    for (int r = 0; r < R; r++) msat[r] = 1'b0;
    tick();
    idle(1);
    check_sat();

    ws_load(2, 2, 2, 1'b0);
    ws_swap();
    ws_load(5, 5, 5, 1'b0);
    ws_load(9, 9, 9, 1'b1);
    vp[0] = AW'(0); vpv[0] = 1'b1;
    vx[0] = '{IW'(0), IW'(0), IW'(1)};
    ws_run(1, 1'b0);
    rand_vecs(6);
    ws_run(6, 1'b0);
    check_sat();

    mode = 1'b1;
    idle(2);
    drive_idle();
    acc_clr = 1'b1;
    for (int r = 0; r < R; r++) msat[r] = 1'b0;
    tick();
    idle(1);
    os_stream(2, 1'b0, 1'b1);
    os_drain(1'b0, 1'b0);
    os_drain(1'b0, 1'b0);

    os_stream(10, 1'b1, 1'b0);
    check_sat();
    os_drain(1'b1, 1'b1);
    check_sat();
    os_stream(6, 1'b1, 1'b0);
    os_drain(1'b1, 1'b0);
    check_sat();

    mode = 1'b0;
    idle(2);
    rand_vecs(6);
    ws_run(6, 1'b0);

    mode = 1'b1;
    idle(2);
    os_stream(4, 1'b0, 1'b0);
    exp_q.push_back('{acc[2], 1'b0});
    drive_idle();
    drain = 1'b1;
    tick();
    drive_idle();
    rst = 1'b1;
    tick();
    check_zero();
    rst = 1'b0;
    model_reset();
    drive_idle();
    tb_nv = 1'b1;
    tb_nl = 1'b1;
    exp_q.push_back('{sxa(tb_n), 1'b1});
    tick();
    idle(5);
    check_busy(1'b0, 1'b0, 1'b0);

    idle(3);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
